// File: rtl/elastic_slice_pkg.sv
// Shared sizing helpers and parameter legality check for the elastic slice buffer.
package elastic_slice_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full buffer (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/elastic_slice_ptr.sv
// Wrapping circular-buffer pointer with increment enable and async active-high reset.
module elastic_slice_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Power-of-two depth lets the pointer wrap by plain overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_en) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/elastic_slice_buffer.sv
// DEPTH-entry ready/valid elastic buffer with fully registered valid_out/ready_out.
// Optional stall/peak statistics outputs are enabled by defining ELASTIC_SLICE_STATS_EN.
module elastic_slice_buffer
  import elastic_slice_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,
  output logic [CNT_W-1:0]      count
`ifdef ELASTIC_SLICE_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [CNT_W-1:0]      peak_count
`endif
);

  localparam int               PTR_W = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("elastic_slice_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  valid_out_q;
  logic                  valid_out_d;
  logic                  ready_out_q;
  logic                  ready_out_d;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  assign push = valid_in & ready_out_q;
  assign pop  = valid_out_q & ready_in;

  elastic_slice_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk    (clk),
    .rst    (reset),
    .inc_en (push),
    .ptr    (wr_ptr)
  );

  elastic_slice_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk    (clk),
    .rst    (reset),
    .inc_en (pop),
    .ptr    (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = data_in;
  end

  // Flags are derived from the next occupancy so they are pure flop outputs.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_out_d = (count_d != '0);
    ready_out_d = (count_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q     <= '0;
      valid_out_q <= 1'b0;
      ready_out_q <= 1'b1;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      valid_out_q <= valid_out_d;
      ready_out_q <= ready_out_d;
    end
  end

  assign ready_out = ready_out_q;
  assign valid_out = valid_out_q;
  assign data_out  = mem_q[rd_ptr];
  assign count     = count_q;

`ifdef ELASTIC_SLICE_STATS_EN
  logic [15:0]      stall_q;
  logic [15:0]      stall_d;
  logic [CNT_W-1:0] peak_q;
  logic [CNT_W-1:0] peak_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_out_q && !ready_in && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      stall_q <= stall_d;
      peak_q  <= peak_d;
    end
  end

  assign stall_cycles = stall_q;
  assign peak_count   = peak_q;
`endif

endmodule

// File: tb/tb_elastic_slice_buffer.sv
// Directed and randomised self-checking bench for elastic_slice_buffer (DEPTH=4, 8-bit data).
module tb_elastic_slice_buffer;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_out;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready_in;
  logic [CNT_W-1:0]      count;
`ifdef ELASTIC_SLICE_STATS_EN
  logic [15:0]           stall_cycles;
  logic [CNT_W-1:0]      peak_count;
`endif

  int errors = 0;
  int checks = 0;

  elastic_slice_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .count     (count)
`ifdef ELASTIC_SLICE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .peak_count   (peak_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got count=%0d valid=%b ready=%b, required count=0 valid=0 ready=1",
               count, valid_out, ready_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (count !== 3'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
        errors++;
        $display("FAIL idle_cycle%0d: got count=%0d valid=%b ready=%b, required count=0 valid=0 ready=1",
                 i, count, valid_out, ready_out);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = vals[i];
      @(negedge clk);
      checks++;
      if (count !== 3'(i + 1) || valid_out !== 1'b1 || data_out !== 8'h11) begin
        errors++;
        $display("FAIL fill_push%0d: got count=%0d valid=%b data=%h, required count=%0d valid=1 data=11",
                 i, count, valid_out, data_out, i + 1);
      end
    end
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got ready_out=%b, required 0", ready_out);
    end
    data_in = 8'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (count !== 3'd4 || ready_out !== 1'b0 || data_out !== 8'h11) begin
        errors++;
        $display("FAIL full_reject%0d: got count=%0d ready=%b data=%h, required count=4 ready=0 data=11",
                 i, count, ready_out, data_out);
      end
    end
`ifdef ELASTIC_SLICE_STATS_EN
    checks++;
    if (peak_count !== 3'd4 || stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL stats_full: got peak=%0d stall=%0d, required peak=4 stall=5", peak_count, stall_cycles);
    end
`endif
    valid_in = 1'b0;
  endtask

  task automatic test_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_out !== 1'b1 || data_out !== vals[i]) begin
        errors++;
        $display("FAIL drain_data%0d: got valid=%b data=%h, required valid=1 data=%h",
                 i, valid_out, data_out, vals[i]);
      end
      @(negedge clk);
      checks++;
      if (count !== 3'(3 - i) || ready_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_count%0d: got count=%0d ready=%b, required count=%0d ready=1",
                 i, count, ready_out, 3 - i);
      end
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got valid_out=%b, required 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(i);
      @(negedge clk);
      checks++;
      if (count !== 3'd1 || valid_out !== 1'b1 || ready_out !== 1'b1 || data_out !== 8'(i)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got count=%0d valid=%b ready=%b data=%h, required count=1 valid=1 ready=1 data=%h",
                 i, count, valid_out, ready_out, data_out, 8'(i));
      end
    end
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got count=%0d valid=%b, required count=0 valid=0", count, valid_out);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int         popped = 0;
    int         cycles = 0;
    bit         vin, rin, pushm, popm, prev_stall;
    logic [7:0] din, prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (popped < 1000 && cycles < 20000) begin
      checks++;
      if (count !== 3'(q.size()) || count > 3'd4 || valid_out !== (q.size() != 0) ||
          ready_out !== (q.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_state@%0d: got count=%0d valid=%b ready=%b, required count=%0d",
                 cycles, count, valid_out, ready_out, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (data_out !== q[0]) begin
          errors++;
          $display("FAIL rand_data@%0d: got data=%h, required %h", cycles, data_out, q[0]);
        end
      end
      if (prev_stall) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== prev_data) begin
          errors++;
          $display("FAIL rand_stall_hold@%0d: got valid=%b data=%h, required valid=1 data=%h",
                   cycles, valid_out, data_out, prev_data);
        end
      end
      vin = ($urandom_range(0, 3) != 0);
      rin = ($urandom_range(0, 2) != 0);
      din = 8'($urandom);
      valid_in = vin;
      ready_in = rin;
      data_in  = din;
      pushm = vin && (q.size() < DEPTH);
      popm  = rin && (q.size() != 0);
      prev_stall = (q.size() != 0) && !rin;
      prev_data  = data_out;
      @(negedge clk);
      cycles++;
      if (popm) begin
        void'(q.pop_front());
        popped++;
      end
      if (pushm) q.push_back(din);
    end
    checks++;
    if (popped < 1000) begin
      errors++;
      $display("FAIL rand_budget: got %0d beats in %0d cycles, required 1000", popped, cycles);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL mid_prefill: got count=%0d, required 3", count);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d valid=%b ready=%b, required count=0 valid=0 ready=1",
               count, valid_out, ready_out);
    end
`ifdef ELASTIC_SLICE_STATS_EN
    checks++;
    if (stall_cycles !== 16'd0 || peak_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_stats: got stall=%0d peak=%0d, required 0 and 0", stall_cycles, peak_count);
    end
`endif
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got count=%0d valid=%b ready=%b, required count=0 valid=0 ready=1",
               count, valid_out, ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
